// File: rtl/alu_result_capture.sv
// Registered capture stage behind the 8-bit ALU: 2-entry skid buffer,
// sticky flag accumulation and a saturating retired-operation counter.
module alu_result_capture #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [WIDTH-1:0] in_result,
  input  logic [3:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_opcode,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [3:0]       sticky_flags,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] res;
    logic [3:0]       flg;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  logic [3:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  entry_t in_e;
  logic   accept;
  logic   retire;

  assign in_e   = {in_opcode, in_result, in_flags};
  assign accept = in_valid && in_ready;
  assign retire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          head_d  = in_e;
        end
      end
      ONE: begin
        if (accept && retire) begin
          head_d = in_e;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = in_e;
        end else if (retire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (retire) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // A clear in the same cycle as an accept only drops older history.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) begin
      sticky_d = 4'b0000;
    end
    if (accept) begin
      sticky_d = (sticky_clr ? 4'b0000 : sticky_q) | in_flags;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (retire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      head_q   <= '0;
      skid_q   <= '0;
      sticky_q <= 4'b0000;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      skid_q   <= skid_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready     = (state_q != FULL) && !rst;
  assign out_valid    = (state_q != EMPTY);
  assign out_opcode   = head_q.op;
  assign out_result   = head_q.res;
  assign out_flags    = head_q.flg;
  assign sticky_flags = sticky_q;
  assign op_count     = cnt_q;

endmodule
